// File: rtl/scaler_vga_timing_out.sv
// VGA timing generator and pixel-stream sink for the scaler output.
// Pulls pixels from a valid/ready stream that carries sop/eop framing. Produces
// 640x480@60 timing by default and drives registered rgb, sync and blank to the DAC.
// After lock loss, underflow or a misplaced sop, it re-aligns the stream to frame start.
// Ports:
//   clk, reset_n           pixel clock; asynchronous active-low reset
//   pll_locked             PLL lock, asynchronous to clk (two-flop synchroniser)
//   in_data/valid/sop/eop  pixel stream from the scaler; in_ready is the handshake back
//   vga_rgb/hs/vs/blank_n  registered DAC outputs; rgb is forced to 0 while blanked
//   frame_start            one-cycle pulse alongside output pixel (0,0)
//   underflow              sticky underflow flag, cleared only by reset
module scaler_vga_timing_out #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned DW       = 30,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pll_locked,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_sop,
   input  logic          in_eop,
   output logic          in_ready,
   output logic [DW-1:0] vga_rgb,
   output logic          vga_hs,
   output logic          vga_vs,
   output logic          vga_blank_n,
   output logic          frame_start,
   output logic          underflow
);

   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {StWaitLock, StSync, StRun} state_e;

   state_e        state_q, state_d;
   logic          lock_meta_q, lock_q;
   logic [11:0]   h_q, h_d, v_q, v_d;
   logic          abort_q, abort_d;
   logic          underflow_d;
   logic [DW-1:0] rgb_d;
   logic          hs_d, vs_d, blank_n_d, fs_d;
   logic          active, origin, last;

   // End-of-frame marker is informational only.
   logic unused_eop;
   assign unused_eop = in_eop;

   assign active = (h_q < H_ACT) && (v_q < V_ACT);
   assign origin = (h_q == 12'd0) && (v_q == 12'd0);
   assign last   = (h_q == H_LAST) && (v_q == V_LAST);

   always_comb begin
      h_d = 12'd0;
      v_d = 12'd0;
      if (lock_q && state_q != StWaitLock) begin
         if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
         end else begin
            h_d = h_q + 12'd1;
            v_d = v_q;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      abort_d     = abort_q;
      underflow_d = underflow;
      in_ready    = 1'b0;
      rgb_d       = '0;
      blank_n_d   = 1'b0;
      fs_d        = 1'b0;
      hs_d        = ~HS_POL;
      vs_d        = ~VS_POL;
      if (!lock_q) begin
         // Lock loss overrides everything, including a pending handshake.
         state_d = StWaitLock;
         abort_d = 1'b0;
      end else begin
         if (h_q >= HS_START && h_q <= HS_END) hs_d = HS_POL;
         if (v_q >= VS_START && v_q <= VS_END) vs_d = VS_POL;
         unique case (state_q)
            StWaitLock: state_d = StSync;
            StSync: begin
               // Drain non-sop beats; hold a sop until the frame is about to wrap.
               in_ready = ~in_sop;
               if (in_valid && in_sop && last) begin
                  state_d = StRun;
                  abort_d = 1'b0;
               end
            end
            StRun: begin
               if (active) begin
                  blank_n_d = 1'b1;
                  fs_d      = origin;
                  in_ready  = ~(in_sop && !origin);
                  if (!in_valid) begin
                     underflow_d = 1'b1;
                     abort_d     = 1'b1;
                  end else if (in_sop && !origin) begin
                     // Misplaced sop stays queued and starts the next frame.
                     state_d = StSync;
                  end else begin
                     rgb_d = in_data;
                  end
               end
               if (last && abort_q) begin
                  state_d = StSync;
                  abort_d = 1'b0;
               end
            end
            default: state_d = StWaitLock;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta_q <= 1'b0;
         lock_q      <= 1'b0;
         state_q     <= StWaitLock;
         h_q         <= 12'd0;
         v_q         <= 12'd0;
         abort_q     <= 1'b0;
         underflow   <= 1'b0;
         vga_rgb     <= '0;
         vga_hs      <= ~HS_POL;
         vga_vs      <= ~VS_POL;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_q      <= lock_meta_q;
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         abort_q     <= abort_d;
         underflow   <= underflow_d;
         vga_rgb     <= rgb_d;
         vga_hs      <= hs_d;
         vga_vs      <= vs_d;
         vga_blank_n <= blank_n_d;
         frame_start <= fs_d;
      end
   end

endmodule
